fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequencer for the instruction-fetch stage of the 5-stage pipeline. Drives the IF stage's PC-write enable (IFWrite), redirect select, redirect address and IF/ID flush.
- Resolves priority between EX-stage branches, ID-stage jumps, load-use hazards and a multi-cycle instruction memory. Sits between the hazard and branch logic and the IF/ID stages.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- BOOT_CYCLES, 4, cycles after reset release during which fetch is held and IF/ID is flushed (1..15).
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- ex_branch_taken  input  1  branch resolved taken in EX this cycle
- ex_branch_target  input  32  branch target address
- id_jump  input  1  jump decoded in ID this cycle
- id_jump_target  input  32  jump target address
- ex_memread  input  1  instruction in EX is a load
- ex_rt  input  5  destination register of the load in EX
- id_rs  input  5  source register rs of the instruction in ID
- id_rt  input  5  source register rt of the instruction in ID
- id_uses_rt  input  1  the ID instruction reads rt
- imem_ready  input  1  instruction memory has valid data for the current request
- pc_write  output  1  PC update enable (IFWrite)
- ifid_write  output  1  IF/ID register load enable
- if_flush  output  1  zero IF/ID on next edge
- idex_flush  output  1  insert bubble into ID/EX
- pc_sel  output  2  0=PC+4, 1=branch target, 2=jump target, 3=hold
- redirect_addr  output  32  selected target when pc_sel is 1 or 2, else 0
- imem_req  output  1  fetch request to instruction memory
- stall_cnt  output  CNT_W  saturating count of stalled cycles
- flush_cnt  output  CNT_W  saturating count of flush events

Behaviour:
- Reset (reset=0, async): state=BOOT, boot counter=BOOT_CYCLES-1, stall_cnt=0, flush_cnt=0.
- Reset output values: pc_write=0, ifid_write=0, if_flush=1, idex_flush=0, pc_sel=3, redirect_addr=0, imem_req=0.
- All outputs are registered-state-derived combinational (Moore for state, Mealy for hazard inputs). Redirect reaches the PC on the same edge it is asserted.
- States:
  - BOOT: if_flush=1, pc_write=0, pc_sel=3. The counter decrements each cycle. At 0, go to FETCH.
  - FETCH: imem_req=1.
  - WAIT_MEM: imem_req=1, pc_write=0, ifid_write=0, pc_sel=3. Stay until imem_ready=1, then go to FETCH.
  - REDIRECT: one cycle, if_flush=1, imem_req=0, pc_write=0. Go to FETCH next cycle.
- Priority in FETCH and WAIT_MEM, highest first:
  1. ex_branch_taken: pc_sel=1, redirect_addr=ex_branch_target, pc_write=1, if_flush=1, idex_flush=1, next=REDIRECT, flush_cnt+1.
  2. id_jump: pc_sel=2, redirect_addr=id_jump_target, pc_write=1, if_flush=1, next=REDIRECT, flush_cnt+1.
  3. Load-use hazard. It is defined as ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)). Response: pc_write=0, ifid_write=0, idex_flush=1, pc_sel=3, stall_cnt+1. State is unchanged.
  4. FETCH with imem_ready=0: next=WAIT_MEM, pc_write=0, ifid_write=0, stall_cnt+1. Each cycle spent in WAIT_MEM also increments stall_cnt.
  5. FETCH with imem_ready=1: pc_sel=0, pc_write=1, ifid_write=1.
- Branch and jump in the same cycle: the branch wins and the jump is discarded, because it is in the wrong-path ID slot.
- A redirect during WAIT_MEM abandons the outstanding fetch. The instruction memory must tolerate imem_req dropping for one cycle.
- Branch, jump and hazard inputs are ignored in BOOT and REDIRECT.
- Counters saturate at all-ones and do not wrap. They increment at most once per cycle.
- Asserting reset in any state returns to BOOT immediately. No partial redirect survives reset.

Test Plan:
- Reset released, BOOT_CYCLES=4, imem_ready=1: if_flush=1 and pc_write=0 for exactly 4 cycles, then pc_write=1 and pc_sel=0 every cycle.
- In FETCH, pulse ex_branch_taken with ex_branch_target=0x40: same cycle pc_sel=1, redirect_addr=0x40, if_flush=1, idex_flush=1. Next cycle REDIRECT with pc_write=0. Then FETCH. flush_cnt=1.
- ex_branch_taken and id_jump together (targets 0x40 and 0x80): pc_sel=1, redirect_addr=0x40, flush_cnt increments by 1 only.
- ex_memread=1, ex_rt=5, id_rs=5: one cycle with pc_write=0, ifid_write=0, idex_flush=1, stall_cnt+1.
  - With ex_rt=0: no stall.
  - With id_rt=5 and id_uses_rt=0: no stall.
- imem_ready held low 3 cycles in FETCH: WAIT_MEM entered, pc_sel=3 and imem_req=1 held, stall_cnt=3. Returns to FETCH the cycle after imem_ready=1.
- CNT_W=4, hold a load-use stall 20 cycles: stall_cnt saturates at 15. Asserting reset mid-stall clears it to 0 asynchronously and restarts BOOT.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: boot hold, branch/jump redirects, load-use stalls
// and multi-cycle instruction memory waits, with saturating stall/flush counters.
module fetch_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  input  logic             id_jump,
  input  logic [31:0]      id_jump_target,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             if_flush,
  output logic             idex_flush,
  output logic [1:0]       pc_sel,
  output logic [31:0]      redirect_addr,
  output logic             imem_req,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {BOOT, FETCH, WAIT_MEM, REDIRECT} state_t;

  localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [3:0] boot_cnt_reg, boot_cnt_next;
  logic       load_use;
  logic       stall_inc;
  logic       flush_inc;

  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= BOOT;
      boot_cnt_reg <= BOOT_INIT;
    end else begin
      state_reg    <= state_next;
      boot_cnt_reg <= boot_cnt_next;
    end
  end

  // Counters stick at all-ones so a long debug run never reads back a small value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_next    = state_reg;
    boot_cnt_next = boot_cnt_reg;
    unique case (state_reg)
      BOOT: begin
        if (boot_cnt_reg == 4'd0)
          state_next = FETCH;
        else
          boot_cnt_next = boot_cnt_reg - 4'd1;
      end
      FETCH, WAIT_MEM: begin
        if (ex_branch_taken || id_jump)
          state_next = REDIRECT;
        else if (load_use)
          state_next = state_reg;
        else if ((state_reg == FETCH) && !imem_ready)
          state_next = WAIT_MEM;
        else if ((state_reg == WAIT_MEM) && imem_ready)
          state_next = FETCH;
      end
      REDIRECT: state_next = FETCH;
      default:  state_next = BOOT;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    ifid_write    = 1'b0;
    if_flush      = 1'b0;
    idex_flush    = 1'b0;
    pc_sel        = 2'd3;
    redirect_addr = 32'd0;
    imem_req      = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    unique case (state_reg)
      BOOT:     if_flush = 1'b1;
      REDIRECT: if_flush = 1'b1;
      FETCH, WAIT_MEM: begin
        imem_req = 1'b1;
        // A taken branch squashes the ID slot, so any jump there is wrong-path.
        if (ex_branch_taken) begin
          pc_sel        = 2'd1;
          redirect_addr = ex_branch_target;
          pc_write      = 1'b1;
          if_flush      = 1'b1;
          idex_flush    = 1'b1;
          flush_inc     = 1'b1;
        end else if (id_jump) begin
          pc_sel        = 2'd2;
          redirect_addr = id_jump_target;
          pc_write      = 1'b1;
          if_flush      = 1'b1;
          flush_inc     = 1'b1;
        end else if (load_use) begin
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
        end else if ((state_reg == WAIT_MEM) || !imem_ready) begin
          stall_inc = 1'b1;
        end else begin
          pc_sel     = 2'd0;
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end
      default: if_flush = 1'b1;
    endcase
  end

endmodule
